// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: pairs two decoded instructions for dual issue, deferring slot 2 on hazards
module dual_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_pc,
    input  logic [4:0]  s1_dst,
    input  logic [4:0]  s2_dst,
    input  logic        s1_we,
    input  logic        s2_we,
    input  logic [4:0]  s2_src1,
    input  logic [4:0]  s2_src2,
    input  logic        s1_mem,
    input  logic        s2_mem,
    input  logic        ex_stall,
    input  logic        redirect,
    output logic        in_ready,
    output logic        iss1_valid,
    output logic        iss2_valid,
    output logic [7:0]  iss1_pc,
    output logic [7:0]  iss2_pc,
    output logic        flush_D_2,
    output logic [15:0] pair_cnt,
    output logic [15:0] split_cnt
);
    typedef enum logic {PAIR, HOLD} state_t;

    state_t     state;
    logic [7:0] hold_pc;
    logic [7:0] pc_next;
    logic       raw;
    logic       waw;
    logic       mem_clash;
    logic       conflict;

    assign pc_next   = in_pc + 8'd1;
    assign raw       = s1_we & (s1_dst != 5'd0) & ((s2_src1 == s1_dst) | (s2_src2 == s1_dst));
    assign waw       = s1_we & s2_we & (s1_dst == s2_dst) & (s1_dst != 5'd0);
    assign mem_clash = s1_mem & s2_mem;
    assign conflict  = raw | waw | mem_clash;
    assign in_ready  = (state == PAIR) & ~ex_stall & ~redirect & ~reset;

    // Issue FSM: redirect flushes, stall freezes, HOLD replays deferred slot 2, PAIR pairs or splits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PAIR;
            hold_pc    <= 8'd0;
            iss1_valid <= 1'b0;
            iss2_valid <= 1'b0;
            iss1_pc    <= 8'd0;
            iss2_pc    <= 8'd0;
            flush_D_2  <= 1'b0;
            pair_cnt   <= 16'd0;
            split_cnt  <= 16'd0;
        end else if (redirect) begin
            state      <= PAIR;
            hold_pc    <= 8'd0;
            iss1_valid <= 1'b0;
            iss2_valid <= 1'b0;
            iss1_pc    <= 8'd0;
            iss2_pc    <= 8'd0;
            flush_D_2  <= 1'b1;
        end else if (!ex_stall) begin
            if (state == HOLD) begin
                state      <= PAIR;
                hold_pc    <= 8'd0;
                iss1_valid <= 1'b1;
                iss1_pc    <= hold_pc;
                iss2_valid <= 1'b0;
                iss2_pc    <= 8'd0;
                flush_D_2  <= 1'b0;
            end else if (in_valid && conflict) begin
                state      <= HOLD;
                hold_pc    <= pc_next;
                iss1_valid <= 1'b1;
                iss1_pc    <= in_pc;
                iss2_valid <= 1'b0;
                iss2_pc    <= 8'd0;
                flush_D_2  <= 1'b1;
                split_cnt  <= split_cnt + {15'd0, split_cnt != 16'hFFFF};
            end else if (in_valid) begin
                iss1_valid <= 1'b1;
                iss1_pc    <= in_pc;
                iss2_valid <= 1'b1;
                iss2_pc    <= pc_next;
                flush_D_2  <= 1'b0;
                pair_cnt   <= pair_cnt + {15'd0, pair_cnt != 16'hFFFF};
            end else begin
                iss1_valid <= 1'b0;
                iss1_pc    <= 8'd0;
                iss2_valid <= 1'b0;
                iss2_pc    <= 8'd0;
                flush_D_2  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb_dual_issue_ctrl: directed stimulus checked against a queue-based issue model and literal expectations
module tb_dual_issue_ctrl;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic [7:0]  in_pc = 0;
    logic [4:0]  s1_dst = 0, s2_dst = 0, s2_src1 = 0, s2_src2 = 0;
    logic        s1_we = 0, s2_we = 0, s1_mem = 0, s2_mem = 0;
    logic        ex_stall = 0, redirect = 0;
    logic        in_ready, iss1_valid, iss2_valid, flush_D_2;
    logic [7:0]  iss1_pc, iss2_pc;
    logic [15:0] pair_cnt, split_cnt;

    int total = 0;
    int bad = 0;
    bit started = 0;

    int         m_pair = 0, m_split = 0;
    logic       m_v1 = 0, m_v2 = 0, m_fl = 0;
    logic [7:0] m_pc1 = 0, m_pc2 = 0;
    logic [7:0] held[$];

    dual_issue_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .s1_dst(s1_dst), .s2_dst(s2_dst), .s1_we(s1_we), .s2_we(s2_we),
        .s2_src1(s2_src1), .s2_src2(s2_src2), .s1_mem(s1_mem), .s2_mem(s2_mem),
        .ex_stall(ex_stall), .redirect(redirect), .in_ready(in_ready),
        .iss1_valid(iss1_valid), .iss2_valid(iss2_valid), .iss1_pc(iss1_pc),
        .iss2_pc(iss2_pc), .flush_D_2(flush_D_2), .pair_cnt(pair_cnt), .split_cnt(split_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hazard(input logic [4:0] d1, input logic w1, input logic [4:0] d2,
                                  input logic w2, input logic [4:0] a, input logic [4:0] b,
                                  input logic m1, input logic m2);
        logic [31:0] wr1, wr2, rd2;
        wr1 = (w1 && d1 != 0) ? (32'd1 << d1) : 32'd0;
        wr2 = w2 ? (32'd1 << d2) : 32'd0;
        rd2 = (32'd1 << a) | (32'd1 << b);
        return ((wr1 & (rd2 | wr2)) != 0) || (m1 && m2);
    endfunction

    function automatic int sat(input int x);
        return x > 65535 ? 65535 : x;
    endfunction

    // Reference model: a deferred slot-2 lives in a queue until it is replayed
    always @(posedge clk or posedge reset) begin
        started = 1;
        if (reset) begin
            m_v1 = 0; m_v2 = 0; m_fl = 0; m_pc1 = 0; m_pc2 = 0;
            m_pair = 0; m_split = 0;
            held.delete();
        end else if (redirect) begin
            m_v1 = 0; m_v2 = 0; m_fl = 1;
            held.delete();
        end else if (!ex_stall) begin
            if (held.size() > 0) begin
                m_v1 = 1; m_pc1 = held.pop_front(); m_v2 = 0; m_fl = 0;
            end else if (in_valid) begin
                m_v1 = 1; m_pc1 = in_pc;
                if (hazard(s1_dst, s1_we, s2_dst, s2_we, s2_src1, s2_src2, s1_mem, s2_mem)) begin
                    m_v2 = 0; m_fl = 1; m_split++;
                    held.push_back(8'(in_pc + 1));
                end else begin
                    m_v2 = 1; m_pc2 = 8'(in_pc + 1); m_fl = 0; m_pair++;
                end
            end else begin
                m_v1 = 0; m_v2 = 0; m_fl = 0;
            end
        end
    end

    // Every cycle, compare the DUT against the model away from the clock edge
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, !reset && held.size() == 0 && !ex_stall && !redirect);
            chk("iss1_valid", iss1_valid, m_v1);
            chk("iss2_valid", iss2_valid, m_v2);
            chk("flush_D_2", flush_D_2, m_fl);
            chk("pair_cnt", pair_cnt, sat(m_pair));
            chk("split_cnt", split_cnt, sat(m_split));
            if (m_v1) chk("iss1_pc", iss1_pc, m_pc1);
            if (m_v2) chk("iss2_pc", iss2_pc, m_pc2);
            chk("iss2_without_iss1", iss2_valid & ~iss1_valid, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; s1_we = 0; s2_we = 0; s1_mem = 0; s2_mem = 0;
        s1_dst = 0; s2_dst = 0; s2_src1 = 0; s2_src2 = 0;
    endtask

    task automatic set_pair(input logic [7:0] pc, input logic [4:0] d1, input logic w1,
                            input logic [4:0] d2, input logic w2, input logic [4:0] a,
                            input logic [4:0] b, input logic m1, input logic m2);
        in_valid = 1; in_pc = pc; s1_dst = d1; s1_we = w1; s2_dst = d2; s2_we = w2;
        s2_src1 = a; s2_src2 = b; s1_mem = m1; s2_mem = m2;
    endtask

    initial begin
        step();
        chk("rst_iss1_valid", iss1_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pair_cnt", pair_cnt, 0);
        step();
        reset = 0;
        step();
        // independent pair
        set_pair(8'h10, 5'd3, 1, 5'd6, 1, 5'd4, 5'd5, 0, 0);
        step();
        idle();
        chk("t1_iss1_pc", iss1_pc, 8'h10);
        chk("t1_iss2_pc", iss2_pc, 8'h11);
        chk("t1_iss2_valid", iss2_valid, 1);
        chk("t1_pair_cnt", pair_cnt, 1);
        step();
        // RAW split, inputs held valid through HOLD to show they are ignored
        set_pair(8'h20, 5'd7, 1, 5'd8, 1, 5'd1, 5'd7, 0, 0);
        #1;
        chk("t2_ready_pair", in_ready, 1);
        step();
        chk("t2_iss1_pc", iss1_pc, 8'h20);
        chk("t2_iss2_valid", iss2_valid, 0);
        chk("t2_iss2_pc", iss2_pc, 8'h00);
        chk("t2_flush", flush_D_2, 1);
        chk("t2_ready_hold", in_ready, 0);
        chk("t2_split_cnt", split_cnt, 1);
        step();
        idle();
        chk("t2_replay_pc", iss1_pc, 8'h21);
        chk("t2_replay_flush", flush_D_2, 0);
        chk("t2_pair_unchanged", pair_cnt, 1);
        step();
        // $zero destination never creates a hazard
        set_pair(8'h30, 5'd0, 1, 5'd0, 1, 5'd0, 5'd0, 0, 0);
        step();
        idle();
        chk("t3_iss2_valid", iss2_valid, 1);
        chk("t3_pair_cnt", pair_cnt, 2);
        chk("t3_split_cnt", split_cnt, 1);
        step();
        // stall while holding a deferred slot
        set_pair(8'h40, 5'd1, 0, 5'd2, 0, 5'd3, 5'd4, 1, 1);
        step();
        idle();
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_frozen_pc", iss1_pc, 8'h40);
            chk("t4_frozen_flush", flush_D_2, 1);
            chk("t4_frozen_split", split_cnt, 2);
        end
        ex_stall = 0;
        step();
        chk("t4_release_pc", iss1_pc, 8'h41);
        step();
        // redirect wins over stall in HOLD
        set_pair(8'h50, 5'd9, 1, 5'd9, 1, 5'd1, 5'd2, 0, 0);
        step();
        idle();
        ex_stall = 1;
        redirect = 1;
        step();
        chk("t5_iss1_valid", iss1_valid, 0);
        chk("t5_flush", flush_D_2, 1);
        redirect = 0;
        ex_stall = 0;
        #1;
        chk("t5_ready", in_ready, 1);
        chk("t5_split_cnt", split_cnt, 3);
        step();
        step();
        // async reset in the middle of a HOLD cycle
        set_pair(8'h60, 5'd5, 1, 5'd6, 1, 5'd5, 5'd1, 0, 0);
        step();
        idle();
        #2;
        reset = 1;
        #1;
        chk("t6_iss1_valid", iss1_valid, 0);
        chk("t6_flush", flush_D_2, 0);
        chk("t6_iss1_pc", iss1_pc, 0);
        chk("t6_split_cnt", split_cnt, 0);
        chk("t6_in_ready", in_ready, 0);
        step();
        reset = 0;
        #1;
        chk("t6_ready_after", in_ready, 1);
        set_pair(8'hFF, 5'd1, 1, 5'd2, 1, 5'd3, 5'd4, 0, 0);
        step();
        idle();
        chk("t6_wrap_pc1", iss1_pc, 8'hFF);
        chk("t6_wrap_pc2", iss2_pc, 8'h00);
        chk("t6_pair_cnt", pair_cnt, 1);
        step();
        // mixed vectors with stalls and a redirect, checked by the model
        for (int i = 0; i < 16; i++) begin
            set_pair(8'(i * 16 + 3), 5'(i), 1, 5'(i % 3 == 0 ? i : i + 1), i % 2,
                     5'(i % 4 == 1 ? i : 31 - i), 5'd30, i % 7 == 3, i % 7 == 3);
            in_valid = (i % 6 != 4);
            ex_stall = (i % 5 == 2);
            redirect = (i == 11);
            step();
        end
        idle();
        ex_stall = 0;
        redirect = 0;
        step();
        step();
        // pair counter saturates
        set_pair(8'h80, 5'd1, 1, 5'd2, 1, 5'd3, 5'd4, 0, 0);
        repeat (65540) step();
        idle();
        chk("t7_pair_sat", pair_cnt, 16'hFFFF);
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dual_issue_ctrl.md
DUAL_ISSUE_CTRL -- requirements
Module: dual_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock for the block; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, decoded instruction pair present.
REQ-004 SHALL have port in_pc, input, 8, PC of slot-1 instruction; slot-2 PC is in_pc+1, mod 256.
REQ-005 SHALL have ports s1_dst/s2_dst, input, 5 each, destination register of slot 1/2.
REQ-006 SHALL have ports s1_we/s2_we, input, 1 each, slot writes register file.
REQ-007 SHALL have ports s2_src1/s2_src2, input, 5 each, slot-2 source registers.
REQ-008 SHALL have ports s1_mem/s2_mem, input, 1 each, slot is load or store.
REQ-009 SHALL have port ex_stall, input, 1, downstream ID/EX hold request (load-use).
REQ-010 SHALL have port redirect, input, 1, branch mispredict flush from EX.
REQ-011 SHALL have port in_ready, output, 1, pair consumed this cycle (combinational).
REQ-012 SHALL have ports iss1_valid/iss2_valid, output, 1 each, registered slot issue valid.
REQ-013 SHALL have ports iss1_pc/iss2_pc, output, 8 each, registered PC of issued slot.
REQ-014 SHALL have port flush_D_2, output, 1, registered: slot 2 bubbled into ID/EX slot-2 register.
REQ-015 SHALL have ports pair_cnt/split_cnt, output, 16 each, saturating event counters.

Function
REQ-016 SHALL implement FSM states PAIR and HOLD; HOLD holds the deferred slot-2 instruction in an 8-bit hold_pc register.
REQ-017 SHALL define conflict = (s1_we & s1_dst!=0 & (s2_src1==s1_dst | s2_src2==s1_dst)) | (s1_we & s2_we & s1_dst==s2_dst & s1_dst!=0) | (s1_mem & s2_mem).
REQ-018 SHALL drive in_ready = (state==PAIR) & ~ex_stall & ~redirect.
REQ-019 SHALL give redirect top priority: next cycle iss1_valid=0, iss2_valid=0, flush_D_2=1, state=PAIR, hold_pc cleared; counters unchanged.
REQ-020 SHALL, with ex_stall=1 and redirect=0, hold all outputs, state, hold_pc and counters unchanged.
REQ-021 SHALL, in PAIR with in_valid=1 and no conflict, issue next cycle iss1=(1,in_pc), iss2=(1,in_pc+1), flush_D_2=0, increment pair_cnt, stay PAIR.
REQ-022 SHALL, in PAIR with in_valid=1 and conflict, issue next cycle iss1=(1,in_pc), iss2_valid=0, iss2_pc=0, flush_D_2=1, capture hold_pc=in_pc+1, increment split_cnt, go HOLD.
REQ-023 SHALL, in PAIR with in_valid=0, issue next cycle both slots invalid, PCs 0, flush_D_2=0.
REQ-024 SHALL, in HOLD (no stall/redirect), issue next cycle iss1=(1,hold_pc), iss2_valid=0, flush_D_2=0, return to PAIR; input ignored (in_ready=0).
REQ-025 SHALL issue with exactly one cycle latency from in_ready acceptance to iss*_valid.
REQ-026 SHALL saturate pair_cnt and split_cnt at 16'hFFFF (no wrap).
REQ-027 SHALL wrap in_pc+1 modulo 256 (8'hFF -> 8'h00).
REQ-028 SHALL never assert iss2_valid without iss1_valid in the same cycle.

Reset
REQ-029 SHALL, while reset=1 and independent of clk, force state=PAIR, hold_pc=0, iss1_valid=iss2_valid=0, iss1_pc=iss2_pc=0, flush_D_2=0, pair_cnt=split_cnt=0.
REQ-030 SHALL hold in_ready=0 while reset=1; reset asserted mid-HOLD discards the held instruction.

Verification
REQ-031 SHALL verify independent pair: in_pc=8'h10, s1_dst=3, s2_src1=4, s2_src2=5, no mem -> next cycle iss1_pc=10, iss2_pc=11, both valid, pair_cnt=1.
REQ-032 SHALL verify RAW split: s1_we=1, s1_dst=7, s2_src2=7, in_pc=8'h20 -> cycle+1 iss1_pc=20 only, flush_D_2=1; cycle+2 iss1_pc=21, in_ready=0 in cycle+1; split_cnt=1.
REQ-033 SHALL verify $zero exemption: s1_dst=0, s2_src1=0, s1_we=s2_we=1 -> paired, no split.
REQ-034 SHALL verify stall in HOLD: split then ex_stall=1 for 3 cycles -> outputs frozen, state HOLD; release -> iss1_pc=hold_pc next cycle.
REQ-035 SHALL verify redirect with ex_stall=1 in HOLD -> next cycle both invalid, flush_D_2=1, state PAIR, in_ready=1 once inputs idle.
REQ-036 SHALL verify async reset pulse mid-cycle in HOLD -> outputs zero immediately, counters 0; in_pc=8'hFF pair afterwards -> iss2_pc=8'h00.
